// File: rtl/mem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_responder_if : CPU request/response bundle for mem_responder
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;

  modport master (
    output cs, we, addr, wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  cs, we, addr, wdata,
    output rdata, ready, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_responder : register-array memory answering CPU requests after WAIT_CYCLES
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mem_responder_if.slave bus
);

  localparam int         c_DEPTH    = 1 << ADDR_W;
  localparam bit         c_NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [2:0] c_CNT_LOAD = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_req_we;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;

  assign w_accept = (r_state == c_IDLE) && bus.cs;

  // With no wait states RESP is entered on the accepting edge, so the commit
  // must use the live request rather than the not-yet-latched copy.
  assign w_req_we    = (r_state == c_IDLE) ? bus.we    : r_we;
  assign w_req_addr  = (r_state == c_IDLE) ? bus.addr  : r_addr;
  assign w_req_wdata = (r_state == c_IDLE) ? bus.wdata : r_wdata;

  assign w_enter_resp = (w_accept && c_NO_WAIT) ||
                        ((r_state == c_WAIT) && (r_cnt == 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.cs) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= c_CNT_LOAD;
            r_state <= c_NO_WAIT ? c_RESP : c_WAIT;
          end
        end
        c_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= c_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enter_resp && w_req_we) begin
      r_mem[w_req_addr] <= w_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_enter_resp && !w_req_we) begin
      r_rdata <= r_mem[w_req_addr];
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = (r_state == c_RESP);
  assign bus.busy  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_responder : directed bench for mem_responder (WAIT_CYCLES 1, 0 and 7)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] wdata = 8'h00;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
  mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
  mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b7 ();

  assign b1.cs = cs;  assign b1.we = we;  assign b1.addr = addr;  assign b1.wdata = wdata;
  assign b0.cs = cs;  assign b0.we = we;  assign b0.addr = addr;  assign b0.wdata = wdata;
  assign b7.cs = cs;  assign b7.we = we;  assign b7.addr = addr;  assign b7.wdata = wdata;

  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(b7));

  // One access on the WAIT_CYCLES=1 instance; returns timing and data observations.
  task automatic access(input logic w, input logic [3:0] a, input logic [7:0] d,
                        input bit scramble, output int lat, output int nbusy,
                        output logic [7:0] rd, output bit idle_ok);
    cs = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (scramble) begin
      addr = 4'h5; wdata = 8'hFF; we = ~w;
    end else begin
      cs = 1'b0;
    end
    lat = 1; nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (b1.busy === 1'b1) nbusy++;
      if (b1.ready === 1'b1) break;
      @(posedge clk); #1;
      lat++;
    end
    rd = b1.rdata;
    cs = 1'b0;
    @(posedge clk); #1;
    idle_ok = (b1.ready === 1'b0) && (b1.busy === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++; if (b1.ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", b1.ready); else n_pass++;
    n_total++; if (b1.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", b1.busy); else n_pass++;
    n_total++; if (b1.rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", b1.rdata); else n_pass++;
  endtask

  task automatic test_read_after_reset();
    int lat, nb; logic [7:0] rd; bit ok;
    rst_n = 1'b1;
    access(1'b0, 4'h3, 8'h00, 1'b0, lat, nb, rd, ok);
    n_total++; if (lat !== 2) $display("FAIL first_read_latency got=%0d exp=2", lat); else n_pass++;
    n_total++; if (nb !== 2) $display("FAIL first_read_busy_cycles got=%0d exp=2", nb); else n_pass++;
    n_total++; if (rd !== 8'h00) $display("FAIL first_read_data got=%h exp=00", rd); else n_pass++;
    n_total++; if (!ok) $display("FAIL first_read_return_idle got=0 exp=1"); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat, nb; logic [7:0] rd; bit ok;
    access(1'b1, 4'h6, 8'h0F, 1'b0, lat, nb, rd, ok);
    n_total++; if (lat !== 2) $display("FAIL write6_latency got=%0d exp=2", lat); else n_pass++;
    n_total++; if (rd !== 8'h00) $display("FAIL write6_rdata_hold got=%h exp=00", rd); else n_pass++;
    access(1'b0, 4'h6, 8'h00, 1'b0, lat, nb, rd, ok);
    n_total++; if (lat !== 2) $display("FAIL read6_latency got=%0d exp=2", lat); else n_pass++;
    n_total++; if (rd !== 8'h0F) $display("FAIL read6_data got=%h exp=0f", rd); else n_pass++;
    n_total++; if (!ok) $display("FAIL read6_single_pulse got=0 exp=1"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0, bad_r = 0, bad_b = 0, bad_rd = 0, bad_hold = 0;
    cs = 1'b1; we = 1'b1; addr = 4'hB; wdata = 8'h0B;
    // Held cs: WAIT, RESP, IDLE repeating from the first accepting edge.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (b1.ready !== (i % 3 == 1)) bad_r++;
      if (b1.busy !== (i % 3 != 2)) bad_b++;
      if (b1.ready === 1'b1) begin
        if (!we && b1.rdata !== 8'h0B) bad_rd++;
        if (we && pulses == 2 && b1.rdata !== 8'h0B) bad_hold++;
        pulses++;
        we = ~we;
        if (pulses == 4) cs = 1'b0;
      end
    end
    n_total++; if (bad_r !== 0) $display("FAIL b2b_ready_pattern got=%0d_bad_cycles exp=0", bad_r); else n_pass++;
    n_total++; if (bad_b !== 0) $display("FAIL b2b_busy_pattern got=%0d_bad_cycles exp=0", bad_b); else n_pass++;
    n_total++; if (pulses !== 4) $display("FAIL b2b_pulse_count got=%0d exp=4", pulses); else n_pass++;
    n_total++; if (bad_rd !== 0) $display("FAIL b2b_read_data got=%0d_bad exp=0", bad_rd); else n_pass++;
    n_total++; if (bad_hold !== 0) $display("FAIL b2b_rdata_hold got=%0d_bad exp=0", bad_hold); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat, nb; logic [7:0] rd; bit ok;
    access(1'b1, 4'h5, 8'h33, 1'b0, lat, nb, rd, ok);
    access(1'b1, 4'h4, 8'h0A, 1'b1, lat, nb, rd, ok);
    n_total++; if (lat !== 2) $display("FAIL scramble_latency got=%0d exp=2", lat); else n_pass++;
    n_total++; if (!ok) $display("FAIL scramble_no_reaccept got=0 exp=1"); else n_pass++;
    access(1'b0, 4'h4, 8'h00, 1'b0, lat, nb, rd, ok);
    n_total++; if (rd !== 8'h0A) $display("FAIL mem4_after_scramble got=%h exp=0a", rd); else n_pass++;
    access(1'b0, 4'h5, 8'h00, 1'b0, lat, nb, rd, ok);
    n_total++; if (rd !== 8'h33) $display("FAIL mem5_untouched got=%h exp=33", rd); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat, nb, nrdy = 0; logic [7:0] rd; bit ok;
    cs = 1'b1; we = 1'b1; addr = 4'h2; wdata = 8'h55;
    @(posedge clk); #1;
    cs = 1'b0;
    n_total++; if (b1.busy !== 1'b1) $display("FAIL abort_in_wait got=%b exp=1", b1.busy); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (b1.busy !== 1'b0) $display("FAIL abort_async_busy got=%b exp=0", b1.busy); else n_pass++;
    n_total++; if (b1.ready !== 1'b0) $display("FAIL abort_async_ready got=%b exp=0", b1.ready); else n_pass++;
    n_total++; if (b1.rdata !== 8'h00) $display("FAIL abort_async_rdata got=%h exp=00", b1.rdata); else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (b1.ready === 1'b1) nrdy++;
    end
    n_total++; if (nrdy !== 0) $display("FAIL abort_no_ready got=%0d exp=0", nrdy); else n_pass++;
    access(1'b0, 4'h2, 8'h00, 1'b0, lat, nb, rd, ok);
    n_total++; if (rd !== 8'h00) $display("FAIL abort_no_commit got=%h exp=00", rd); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL abort_read_latency got=%0d exp=2", lat); else n_pass++;
    access(1'b0, 4'h6, 8'h00, 1'b0, lat, nb, rd, ok);
    n_total++; if (rd !== 8'h00) $display("FAIL reset_clears_mem got=%h exp=00", rd); else n_pass++;
  endtask

  task automatic test_wait_params();
    int first0 = -1, first7 = -1, p0 = 0, p7 = 0, nb7 = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    cs = 1'b1; we = 1'b0; addr = 4'h1; wdata = 8'h00;
    @(posedge clk); #1;
    cs = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (b0.ready === 1'b1) begin p0++; if (first0 < 0) first0 = c; end
      if (b7.ready === 1'b1) begin p7++; if (first7 < 0) first7 = c; end
      if (b7.busy === 1'b1) nb7++;
      @(posedge clk); #1;
    end
    n_total++; if (first0 !== 1) $display("FAIL w0_latency got=%0d exp=1", first0); else n_pass++;
    n_total++; if (p0 !== 1) $display("FAIL w0_pulses got=%0d exp=1", p0); else n_pass++;
    n_total++; if (first7 !== 8) $display("FAIL w7_latency got=%0d exp=8", first7); else n_pass++;
    n_total++; if (p7 !== 1) $display("FAIL w7_pulses got=%0d exp=1", p7); else n_pass++;
    n_total++; if (nb7 !== 8) $display("FAIL w7_busy_cycles got=%0d exp=8", nb7); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_wait_params();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
